// File: rtl/an13_pkg.sv
// Shared constants, status encoding and the A=13 syndrome table for the AN-code corrector.
package an13_pkg;

  localparam int unsigned A        = 13;
  localparam int unsigned CW_W     = 6;
  localparam int unsigned Q_W      = 3;
  localparam int unsigned R_W      = 4;
  localparam int unsigned Q_MAX    = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned ALARM_TH = 8;
  localparam int unsigned QC_W     = Q_W + 2;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,
    ST_CORR   = 2'b01,
    ST_UNCORR = 2'b10
  } status_e;

  typedef struct packed {
    logic            hit;
    logic            neg;
    logic [2:0]      idx;
    logic [QC_W-1:0] delta;
  } synd_t;

  // Maps a remainder to the +/-2^i error that produces it; delta is the quotient fix-up.
  function automatic synd_t synd_lookup(input logic [R_W-1:0] r);
    synd_t s;
    s     = '0;
    s.hit = 1'b1;
    case (r)
      4'd1:  s.idx = 3'd0;
      4'd2:  s.idx = 3'd1;
      4'd4:  s.idx = 3'd2;
      4'd8:  s.idx = 3'd3;
      4'd3:  begin s.idx = 3'd4; s.delta = -5'sd1; end
      4'd6:  begin s.idx = 3'd5; s.delta = -5'sd2; end
      4'd12: begin s.neg = 1'b1; s.idx = 3'd0; s.delta = 5'sd1; end
      4'd11: begin s.neg = 1'b1; s.idx = 3'd1; s.delta = 5'sd1; end
      4'd9:  begin s.neg = 1'b1; s.idx = 3'd2; s.delta = 5'sd1; end
      4'd5:  begin s.neg = 1'b1; s.idx = 3'd3; s.delta = 5'sd1; end
      4'd10: begin s.neg = 1'b1; s.idx = 3'd4; s.delta = 5'sd2; end
      4'd7:  begin s.neg = 1'b1; s.idx = 3'd5; s.delta = 5'sd3; end
      default: s.hit = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/an13_stat_counters.sv
// Saturating corrected/uncorrectable counters with clear priority and a sticky alarm.
module an13_stat_counters
  import an13_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             fire,
  input  logic [1:0]       status,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorr,
  output logic             alarm
);

  logic [CNT_W-1:0] corr_q, uncorr_q;
  logic             alarm_q;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      corr_q   <= '0;
      uncorr_q <= '0;
      alarm_q  <= 1'b0;
    end else begin
      if (fire && status == ST_CORR && !(&corr_q)) begin
        corr_q <= corr_q + CNT_W'(1);
      end
      if (fire && status == ST_UNCORR && !(&uncorr_q)) begin
        uncorr_q <= uncorr_q + CNT_W'(1);
      end
      // Looks at the registered count, so the alarm lands one cycle after the threshold.
      if (uncorr_q >= CNT_W'(ALARM_TH)) begin
        alarm_q <= 1'b1;
      end
    end
  end

  assign cnt_corrected = corr_q;
  assign cnt_uncorr    = uncorr_q;
  assign alarm         = alarm_q;

endmodule

// File: rtl/an13_correct_stage.sv
// Two-stage AN-code (A=13) single-bit corrector: S1 registers inputs plus syndrome lookup,
// S2 registers the corrected result behind a valid/ready output.
module an13_correct_stage
  import an13_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_codeword,
  input  logic [Q_W-1:0]   in_q,
  input  logic [R_W-1:0]   in_r,
  input  logic             in_error,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Q_W-1:0]   out_data,
  output logic [1:0]       out_status,
  output logic [2:0]       out_bitpos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_corrected,
  output logic [CNT_W-1:0] cnt_uncorr,
  output logic             alarm
);

  localparam logic signed [QC_W-1:0] QMaxS = QC_W'(Q_MAX);

  logic            s1_valid_q;
  logic [CW_W-1:0] s1_cw_q;
  logic [Q_W-1:0]  s1_q_q;
  logic            s1_err_q;
  synd_t           s1_synd_q;

  logic            s2_valid_q;
  logic [Q_W-1:0]  data_q;
  status_e         status_q;
  logic [2:0]      bitpos_q;

  logic            s2_load;
  logic            fire;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_load;
  assign fire     = s2_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_cw_q    <= '0;
      s1_q_q     <= '0;
      s1_err_q   <= 1'b0;
      s1_synd_q  <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_cw_q   <= in_codeword;
        s1_q_q    <= in_q;
        s1_err_q  <= in_error;
        s1_synd_q <= synd_lookup(in_r);
      end
    end
  end

  logic signed [QC_W-1:0] q_corr;
  logic                   bit_ok;
  logic                   corr_ok;
  logic [Q_W-1:0]         data_d;
  status_e                status_d;
  logic [2:0]             bitpos_d;

  always_comb begin
    q_corr   = $signed({2'b00, s1_q_q}) + $signed(s1_synd_q.delta);
    // A positive error set a 0 bit to 1, a negative one cleared a 1 bit.
    bit_ok   = s1_cw_q[s1_synd_q.idx] == !s1_synd_q.neg;
    corr_ok  = s1_synd_q.hit && bit_ok && (q_corr >= 0) && (q_corr <= QMaxS);
    data_d   = s1_q_q;
    status_d = ST_CLEAN;
    bitpos_d = '0;
    if (s1_err_q) begin
      if (corr_ok) begin
        data_d   = q_corr[Q_W-1:0];
        status_d = ST_CORR;
        bitpos_d = s1_synd_q.idx;
      end else begin
        status_d = ST_UNCORR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      data_q     <= '0;
      status_q   <= ST_CLEAN;
      bitpos_q   <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q   <= data_d;
        status_q <= status_d;
        bitpos_q <= bitpos_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = data_q;
  assign out_status = status_q;
  assign out_bitpos = bitpos_q;

  an13_stat_counters u_stats (
    .clk           (clk),
    .rst           (rst),
    .fire          (fire),
    .status        (status_q),
    .cnt_clr       (cnt_clr),
    .cnt_corrected (cnt_corrected),
    .cnt_uncorr    (cnt_uncorr),
    .alarm         (alarm)
  );

endmodule

// File: tb/tb_an13_correct_stage.sv
// Bench for an13_correct_stage: directed test-plan words, backpressure, then random traffic
// scored against an arithmetic model of AN-code single-bit correction.
module tb_an13_correct_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [5:0]  in_codeword;
  logic [2:0]  in_q;
  logic [3:0]  in_r;
  logic        in_error;
  logic        out_valid, out_ready;
  logic [2:0]  out_data;
  logic [1:0]  out_status;
  logic [2:0]  out_bitpos;
  logic        cnt_clr;
  logic [15:0] cnt_corrected, cnt_uncorr;
  logic        alarm;

  always #5 clk = ~clk;

  an13_correct_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_codeword   (in_codeword),
    .in_q          (in_q),
    .in_r          (in_r),
    .in_error      (in_error),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_status    (out_status),
    .out_bitpos    (out_bitpos),
    .cnt_clr       (cnt_clr),
    .cnt_corrected (cnt_corrected),
    .cnt_uncorr    (cnt_uncorr),
    .alarm         (alarm)
  );

  typedef struct {
    int data;
    int status;
    int bitpos;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  int   m_corr, m_unc;
  bit   m_alarm;
  bit   hold_pend;
  exp_t hold_v;
  bit   seen_ov, seen_ir, acc_flag;
  exp_t last_out;
  int   nout;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Received word is 13q+r; find the power of two whose addition or removal gives a multiple.
  function automatic exp_t model(input int cw, input int q, input int r, input int err);
    exp_t e;
    e.data = q; e.status = 0; e.bitpos = 0;
    if (err == 0) return e;
    e.status = 2;
    for (int i = 0; i < 6; i++) begin
      int p = 1 << i;
      int d = 0;
      int need = -1;
      if (p % 13 == r) begin need = 1; d = (r - p) / 13; end
      else if ((r + p) % 13 == 0) begin need = 0; d = (r + p) / 13; end
      if (need >= 0) begin
        if (((cw >> i) & 1) == need && q + d >= 0 && q + d <= 4) begin
          e.data = q + d; e.status = 1; e.bitpos = i;
        end
        break;
      end
    end
    return e;
  endfunction

  task automatic cyc(input bit iv, input int cw, input int q, input int r, input int err,
                     input bit ordy, input bit clr);
    bit   fire;
    bit   nalarm;
    exp_t e;
    in_valid = iv; in_codeword = cw[5:0]; in_q = q[2:0]; in_r = r[3:0]; in_error = err[0];
    out_ready = ordy; cnt_clr = clr;
    #1;
    seen_ov = out_valid; seen_ir = in_ready;
    if (hold_pend) begin
      check_eq("hold_valid", 32'(out_valid), 1);
      check_eq("hold_data", 32'(out_data), hold_v.data);
      check_eq("hold_status", 32'(out_status), hold_v.status);
      check_eq("hold_bitpos", 32'(out_bitpos), hold_v.bitpos);
    end
    hold_pend = out_valid && !out_ready;
    hold_v.data = out_data; hold_v.status = out_status; hold_v.bitpos = out_bitpos;
    acc_flag = in_valid && in_ready;
    if (acc_flag) expq.push_back(model(cw, q, r, err));
    fire = out_valid && out_ready;
    if (fire) begin
      if (expq.size() == 0) begin
        check_eq("spurious_out", 1, 0);
      end else begin
        e = expq.pop_front();
        check_eq("out_data", 32'(out_data), e.data);
        check_eq("out_status", 32'(out_status), e.status);
        check_eq("out_bitpos", 32'(out_bitpos), e.bitpos);
        last_out.data = out_data; last_out.status = out_status; last_out.bitpos = out_bitpos;
        nout++;
      end
    end
    nalarm = clr ? 1'b0 : (m_alarm || m_unc >= 8);
    if (clr) begin
      m_corr = 0; m_unc = 0;
    end else if (fire) begin
      if (out_status == 2'b01 && m_corr < 65535) m_corr++;
      if (out_status == 2'b10 && m_unc < 65535) m_unc++;
    end
    m_alarm = nalarm;
    @(posedge clk); #1;
    check_eq("cnt_corrected", 32'(cnt_corrected), m_corr);
    check_eq("cnt_uncorr", 32'(cnt_uncorr), m_unc);
    check_eq("alarm", 32'(alarm), 32'(m_alarm));
  endtask

  task automatic send_one(input int cw, input int q, input int r, input int err);
    cyc(1, cw, q, r, err, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_codeword = '0; in_q = '0; in_r = '0; in_error = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete(); hold_pend = 0; m_corr = 0; m_unc = 0; m_alarm = 0;
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_data", 32'(out_data), 0);
    check_eq("rst_out_status", 32'(out_status), 0);
    check_eq("rst_cnt_corr", 32'(cnt_corrected), 0);
    check_eq("rst_cnt_unc", 32'(cnt_uncorr), 0);
    check_eq("rst_alarm", 32'(alarm), 0);
  endtask

  initial begin
    int cws[3];
    int idx;
    int n0;
    nout = 0;
    do_reset();

    // Clean word with latency measurement.
    cyc(1, 39, 3, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_eq("lat_cycle1_idle", 32'(seen_ov), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_eq("lat_cycle2_valid", 32'(seen_ov), 1);
    check_eq("clean_data", 32'(last_out.data), 3);
    check_eq("clean_status", 32'(last_out.status), 0);
    check_eq("clean_cnt", 32'(cnt_corrected), 0);

    send_one(37, 2, 11, 1);
    check_eq("neg_data", 32'(last_out.data), 3);
    check_eq("neg_status", 32'(last_out.status), 1);
    check_eq("neg_bitpos", 32'(last_out.bitpos), 1);
    check_eq("neg_cnt", 32'(cnt_corrected), 1);

    send_one(10, 0, 10, 1);
    check_eq("bigneg_data", 32'(last_out.data), 2);
    check_eq("bigneg_bitpos", 32'(last_out.bitpos), 4);

    send_one(45, 3, 6, 1);
    check_eq("pos_data", 32'(last_out.data), 1);
    check_eq("pos_status", 32'(last_out.status), 1);
    check_eq("pos_bitpos", 32'(last_out.bitpos), 5);

    send_one(63, 4, 11, 1);
    check_eq("unc_status", 32'(last_out.status), 2);
    check_eq("unc_data", 32'(last_out.data), 4);
    check_eq("unc_cnt", 32'(cnt_uncorr), 1);
    for (int k = 0; k < 7; k++) send_one(63, 4, 11, 1);
    check_eq("unc_cnt8", 32'(cnt_uncorr), 8);
    check_eq("alarm_lag", 32'(alarm), 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_eq("alarm_set", 32'(alarm), 1);

    cyc(1, 63, 4, 11, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    check_eq("clr_fire_cnt", 32'(cnt_uncorr), 0);
    check_eq("clr_fire_alarm", 32'(alarm), 0);

    // Backpressure: three words offered while the sink stalls.
    cws[0] = 13; cws[1] = 26; cws[2] = 52;
    idx = 0;
    n0 = nout;
    for (int k = 0; k < 5; k++) begin
      cyc(idx < 3, cws[idx % 3], cws[idx % 3] / 13, 0, 0, 0, 0);
      if (acc_flag) idx++;
    end
    check_eq("bp_accepted", 32'(idx), 2);
    check_eq("bp_in_ready", 32'(seen_ir), 0);
    for (int k = 0; k < 20 && (idx < 3 || expq.size() != 0); k++) begin
      cyc(idx < 3, cws[idx % 3], cws[idx % 3] / 13, 0, 0, 1, 0);
      if (acc_flag) idx++;
    end
    check_eq("bp_drained", 32'(nout - n0), 3);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      int mode = $urandom_range(0, 9);
      int cw = $urandom_range(0, 63);
      int q = cw / 13;
      int r = cw % 13;
      int err = (r != 0) ? 1 : 0;
      if (mode == 7) begin
        q = $urandom_range(0, 7); r = $urandom_range(0, 15); err = 1;
      end else if (mode == 8) begin
        q = $urandom_range(0, 7); r = $urandom_range(0, 15); err = 0;
      end else if (mode == 9) begin
        cw = (13 * $urandom_range(0, 4)) ^ (1 << $urandom_range(0, 5));
        q = cw / 13; r = cw % 13; err = (r != 0) ? 1 : 0;
      end
      cyc($urandom_range(0, 3) != 0, cw, q, r, err, $urandom_range(0, 9) < 7,
          $urandom_range(0, 299) == 0);
    end

    // Reset with words in flight.
    cyc(1, 45, 3, 6, 1, 0, 0);
    cyc(1, 37, 2, 11, 1, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_eq("midrst_no_out", 32'(seen_ov), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
